// File: rtl/ooo_scoreboard.sv
module ooo_scoreboard #(
  parameter int unsigned DEPTH        = 8,
  parameter int unsigned IDX_W        = $clog2(DEPTH),
  parameter int unsigned WB_PORTS     = 2,
  parameter int unsigned COMMIT_PORTS = 2,
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned REG_W        = 5
) (
  input  logic                                  clk_i,
  input  logic                                  rst_ni,
  input  logic                                  flush_i,
  input  logic                                  alloc_valid_i,
  output logic                                  alloc_ready_o,
  input  logic [REG_W-1:0]                      alloc_rd_i,
  input  logic [31:0]                           alloc_pc_i,
  output logic [IDX_W-1:0]                      alloc_idx_o,
  input  logic                                  issue_valid_i,
  input  logic [IDX_W-1:0]                      issue_idx_i,
  output logic [DEPTH-1:0]                      issued_o,
  input  logic [WB_PORTS-1:0]                   wb_valid_i,
  input  logic [WB_PORTS-1:0][IDX_W-1:0]        wb_idx_i,
  input  logic [WB_PORTS-1:0][DATA_W-1:0]       wb_data_i,
  input  logic [1:0][REG_W-1:0]                 rs_i,
  output logic [1:0]                            rs_busy_o,
  output logic [1:0]                            rs_fwd_valid_o,
  output logic [1:0][DATA_W-1:0]                rs_fwd_data_o,
  output logic [COMMIT_PORTS-1:0]               commit_valid_o,
  output logic [COMMIT_PORTS-1:0][REG_W-1:0]    commit_rd_o,
  output logic [COMMIT_PORTS-1:0][DATA_W-1:0]   commit_data_o,
  output logic [COMMIT_PORTS-1:0][31:0]         commit_pc_o,
  input  logic [COMMIT_PORTS-1:0]               commit_ack_i
);

  localparam int unsigned CNT_W = IDX_W + 1;

  logic [DEPTH-1:0]  valid_q;
  logic [DEPTH-1:0]  issued_q;
  logic [DEPTH-1:0]  done_q;
  logic [REG_W-1:0]  rd_q     [DEPTH];
  logic [31:0]       pc_q     [DEPTH];
  logic [DATA_W-1:0] result_q [DEPTH];
  logic [IDX_W-1:0]  head_q;
  logic [IDX_W-1:0]  tail_q;
  logic [CNT_W-1:0]  count_q;

  logic              alloc_fire;
  logic [CNT_W-1:0]  retire_n;

  assign alloc_ready_o = (count_q != CNT_W'(DEPTH));
  assign alloc_idx_o   = tail_q;
  assign alloc_fire    = alloc_valid_i && alloc_ready_o;
  assign issued_o      = issued_q;

  always_comb begin
    logic             chain;
    logic             run;
    logic [IDX_W-1:0] slot;
    commit_valid_o = '0;
    commit_rd_o    = '0;
    commit_data_o  = '0;
    commit_pc_o    = '0;
    retire_n       = '0;
    chain          = 1'b1;
    run            = 1'b1;
    slot           = '0;
    for (int unsigned k = 0; k < COMMIT_PORTS; k++) begin
      slot  = head_q + IDX_W'(k);
      chain = chain && (CNT_W'(k) < count_q) && valid_q[slot] && done_q[slot];
      commit_valid_o[k] = chain;
      if (chain) begin
        commit_rd_o[k]   = rd_q[slot];
        commit_data_o[k] = result_q[slot];
        commit_pc_o[k]   = pc_q[slot];
      end
      run = run && chain && commit_ack_i[k];
      if (run) begin
        retire_n = retire_n + CNT_W'(1);
      end
    end
  end

  always_comb begin
    logic             hit;
    logic             byp;
    logic [IDX_W-1:0] match;
    logic [IDX_W-1:0] slot;
    logic [DATA_W-1:0] byp_data;
    rs_busy_o      = '0;
    rs_fwd_valid_o = '0;
    rs_fwd_data_o  = '0;
    hit            = 1'b0;
    byp            = 1'b0;
    match          = '0;
    slot           = '0;
    byp_data       = '0;
    for (int unsigned o = 0; o < 2; o++) begin
      hit   = 1'b0;
      match = '0;
      // Scan oldest to youngest so the last hit is the youngest producer.
      for (int unsigned j = 0; j < DEPTH; j++) begin
        slot = head_q + IDX_W'(j);
        if ((CNT_W'(j) < count_q) && valid_q[slot] && (rs_i[o] != '0) && (rd_q[slot] == rs_i[o])) begin
          hit   = 1'b1;
          match = slot;
        end
      end
      byp      = 1'b0;
      byp_data = '0;
      // Highest port first so the lowest matching port is the one kept.
      for (int unsigned i = 0; i < WB_PORTS; i++) begin
        if (wb_valid_i[WB_PORTS-1-i] && (wb_idx_i[WB_PORTS-1-i] == match)) begin
          byp      = 1'b1;
          byp_data = wb_data_i[WB_PORTS-1-i];
        end
      end
      if (hit) begin
        if (done_q[match]) begin
          rs_fwd_valid_o[o] = 1'b1;
          rs_fwd_data_o[o]  = result_q[match];
        end else if (byp) begin
          rs_fwd_valid_o[o] = 1'b1;
          rs_fwd_data_o[o]  = byp_data;
        end else begin
          rs_busy_o[o] = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      valid_q  <= '0;
      issued_q <= '0;
      done_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
      for (int unsigned e = 0; e < DEPTH; e++) begin
        rd_q[e]     <= '0;
        pc_q[e]     <= '0;
        result_q[e] <= '0;
      end
    end else if (flush_i) begin
      valid_q  <= '0;
      issued_q <= '0;
      done_q   <= '0;
      head_q   <= '0;
      tail_q   <= '0;
      count_q  <= '0;
    end else begin
      if (issue_valid_i && valid_q[issue_idx_i]) begin
        issued_q[issue_idx_i] <= 1'b1;
      end
      // Highest port first: later non-blocking writes win, giving the lowest port priority.
      for (int unsigned i = 0; i < WB_PORTS; i++) begin
        if (wb_valid_i[WB_PORTS-1-i] && valid_q[wb_idx_i[WB_PORTS-1-i]] &&
            !done_q[wb_idx_i[WB_PORTS-1-i]]) begin
          done_q[wb_idx_i[WB_PORTS-1-i]]   <= 1'b1;
          result_q[wb_idx_i[WB_PORTS-1-i]] <= wb_data_i[WB_PORTS-1-i];
        end
      end
      for (int unsigned k = 0; k < COMMIT_PORTS; k++) begin
        if (CNT_W'(k) < retire_n) begin
          valid_q[head_q + IDX_W'(k)]  <= 1'b0;
          issued_q[head_q + IDX_W'(k)] <= 1'b0;
          done_q[head_q + IDX_W'(k)]   <= 1'b0;
          rd_q[head_q + IDX_W'(k)]     <= '0;
          pc_q[head_q + IDX_W'(k)]     <= '0;
          result_q[head_q + IDX_W'(k)] <= '0;
        end
      end
      if (alloc_fire) begin
        valid_q[tail_q]  <= 1'b1;
        issued_q[tail_q] <= 1'b0;
        done_q[tail_q]   <= 1'b0;
        rd_q[tail_q]     <= alloc_rd_i;
        pc_q[tail_q]     <= alloc_pc_i;
        result_q[tail_q] <= '0;
        tail_q           <= tail_q + IDX_W'(1);
      end
      head_q  <= head_q + IDX_W'(retire_n);
      count_q <= count_q + CNT_W'(alloc_fire) - retire_n;
    end
  end

  logic wb_dup;
  logic wb_bad;
  logic ack_bad;

  always_comb begin
    wb_dup  = 1'b0;
    wb_bad  = 1'b0;
    ack_bad = 1'b0;
    for (int unsigned p = 0; p < WB_PORTS; p++) begin
      if (wb_valid_i[p] && (!valid_q[wb_idx_i[p]] || done_q[wb_idx_i[p]])) begin
        wb_bad = 1'b1;
      end
      for (int unsigned r = p + 1; r < WB_PORTS; r++) begin
        if (wb_valid_i[p] && wb_valid_i[r] && (wb_idx_i[p] == wb_idx_i[r])) begin
          wb_dup = 1'b1;
        end
      end
    end
    for (int unsigned k = 0; k < COMMIT_PORTS; k++) begin
      if (commit_ack_i[k] && !commit_valid_o[k]) begin
        ack_bad = 1'b1;
      end
    end
    for (int unsigned k = 1; k < COMMIT_PORTS; k++) begin
      if (commit_ack_i[k] && !commit_ack_i[k-1]) begin
        ack_bad = 1'b1;
      end
    end
  end

  a_wb_dup:  assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i) !wb_dup);
  a_wb_bad:  assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i) !wb_bad);
  a_ack_bad: assert property (@(posedge clk_i) disable iff (!rst_ni || flush_i) !ack_bad);

endmodule

// File: tb/tb_ooo_scoreboard.sv
module tb_ooo_scoreboard;

  localparam int unsigned DEPTH = 8;
  localparam int unsigned IDX_W = 3;
  localparam int unsigned WB    = 2;
  localparam int unsigned CP    = 3;
  localparam int unsigned DW    = 32;
  localparam int unsigned RW    = 5;

  logic                     clk = 1'b0;
  logic                     rst_n;
  logic                     flush;
  logic                     alloc_valid;
  logic                     alloc_ready;
  logic [RW-1:0]            alloc_rd;
  logic [31:0]              alloc_pc;
  logic [IDX_W-1:0]         alloc_idx;
  logic                     issue_valid;
  logic [IDX_W-1:0]         issue_idx;
  logic [DEPTH-1:0]         issued;
  logic [WB-1:0]            wb_valid;
  logic [WB-1:0][IDX_W-1:0] wb_idx;
  logic [WB-1:0][DW-1:0]    wb_data;
  logic [1:0][RW-1:0]       rs;
  logic [1:0]               rs_busy;
  logic [1:0]               rs_fwd_valid;
  logic [1:0][DW-1:0]       rs_fwd_data;
  logic [CP-1:0]            commit_valid;
  logic [CP-1:0][RW-1:0]    commit_rd;
  logic [CP-1:0][DW-1:0]    commit_data;
  logic [CP-1:0][31:0]      commit_pc;
  logic [CP-1:0]            commit_ack;

  ooo_scoreboard #(
    .DEPTH(DEPTH), .WB_PORTS(WB), .COMMIT_PORTS(CP), .DATA_W(DW), .REG_W(RW)
  ) dut (
    .clk_i(clk), .rst_ni(rst_n), .flush_i(flush),
    .alloc_valid_i(alloc_valid), .alloc_ready_o(alloc_ready), .alloc_rd_i(alloc_rd),
    .alloc_pc_i(alloc_pc), .alloc_idx_o(alloc_idx),
    .issue_valid_i(issue_valid), .issue_idx_i(issue_idx), .issued_o(issued),
    .wb_valid_i(wb_valid), .wb_idx_i(wb_idx), .wb_data_i(wb_data),
    .rs_i(rs), .rs_busy_o(rs_busy), .rs_fwd_valid_o(rs_fwd_valid), .rs_fwd_data_o(rs_fwd_data),
    .commit_valid_o(commit_valid), .commit_rd_o(commit_rd), .commit_data_o(commit_data),
    .commit_pc_o(commit_pc), .commit_ack_i(commit_ack)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          idx;
    logic [RW-1:0] rd;
    logic [31:0] pc;
    bit          issued;
    bit          done;
    logic [DW-1:0] res;
  } ent_t;

  ent_t q[$];
  int   m_tail = 0;
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic int exp_commit_n();
    int n = 0;
    for (int k = 0; k < int'(CP) && k < q.size(); k++) begin
      if (q[k].done) n++;
      else break;
    end
    return n;
  endfunction

  task automatic check_model();
    logic [DEPTH-1:0] eiss;
    int n;
    n = exp_commit_n();
    chk("alloc_ready", 64'(alloc_ready), 64'(q.size() != int'(DEPTH)));
    chk("alloc_idx", 64'(alloc_idx), 64'(m_tail));
    eiss = '0;
    foreach (q[i]) if (q[i].issued) eiss[q[i].idx] = 1'b1;
    chk("issued", 64'(issued), 64'(eiss));
    for (int k = 0; k < int'(CP); k++) begin
      if (k < n) begin
        chk("commit_valid", 64'(commit_valid[k]), 64'd1);
        chk("commit_rd", 64'(commit_rd[k]), 64'(q[k].rd));
        chk("commit_data", 64'(commit_data[k]), 64'(q[k].res));
        chk("commit_pc", 64'(commit_pc[k]), 64'(q[k].pc));
      end else begin
        chk("commit_valid", 64'(commit_valid[k]), 64'd0);
      end
    end
    for (int o = 0; o < 2; o++) begin
      int mi;
      bit eb, ef;
      logic [DW-1:0] ed;
      mi = -1; eb = 0; ef = 0; ed = '0;
      if (rs[o] != '0) begin
        for (int i = q.size() - 1; i >= 0; i--) begin
          if (q[i].rd == rs[o]) begin mi = i; break; end
        end
      end
      if (mi >= 0) begin
        if (q[mi].done) begin
          ef = 1; ed = q[mi].res;
        end else begin
          for (int p = 0; p < int'(WB); p++) begin
            if (wb_valid[p] && int'(wb_idx[p]) == q[mi].idx) begin
              ef = 1; ed = wb_data[p]; break;
            end
          end
          if (!ef) eb = 1;
        end
      end
      chk("rs_busy", 64'(rs_busy[o]), 64'(eb));
      chk("rs_fwd_valid", 64'(rs_fwd_valid[o]), 64'(ef));
      if (ef || mi < 0) chk("rs_fwd_data", 64'(rs_fwd_data[o]), 64'(ed));
    end
  endtask

  task automatic update_model();
    bit ok;
    int n;
    if (flush) begin
      q.delete();
      m_tail = 0;
      return;
    end
    ok = (q.size() != int'(DEPTH));
    if (issue_valid) foreach (q[i]) if (q[i].idx == int'(issue_idx)) q[i].issued = 1;
    for (int p = 0; p < int'(WB); p++) begin
      if (wb_valid[p]) begin
        foreach (q[i]) begin
          if (q[i].idx == int'(wb_idx[p]) && !q[i].done) begin
            q[i].done = 1;
            q[i].res  = wb_data[p];
          end
        end
      end
    end
    n = 0;
    for (int k = 0; k < int'(CP); k++) begin
      if (commit_ack[k]) n++;
      else break;
    end
    repeat (n) void'(q.pop_front());
    if (alloc_valid && ok) begin
      q.push_back('{idx: m_tail, rd: alloc_rd, pc: alloc_pc, issued: 1'b0, done: 1'b0, res: '0});
      m_tail = (m_tail + 1) % int'(DEPTH);
    end
  endtask

  task automatic idle();
    flush = 0; alloc_valid = 0; alloc_rd = '0; alloc_pc = '0;
    issue_valid = 0; issue_idx = '0; wb_valid = '0; wb_idx = '0; wb_data = '0;
    rs = '0; commit_ack = '0;
  endtask

  task automatic tick();
    @(negedge clk);
    check_model();
    @(posedge clk);
    update_model();
    #1;
    idle();
  endtask

  task automatic alloc_one(input int rd, input int pc);
    alloc_valid = 1;
    alloc_rd    = RW'(rd);
    alloc_pc    = 32'(pc);
    tick();
  endtask

  task automatic rand_wb(input int max_ports);
    int cand[$];
    int j;
    foreach (q[i]) if (!q[i].done) cand.push_back(q[i].idx);
    for (int p = 0; p < max_ports && p < int'(WB); p++) begin
      if (cand.size() > 0 && $urandom_range(0, 3) != 0) begin
        j = int'($urandom_range(0, cand.size() - 1));
        wb_valid[p] = 1'b1;
        wb_idx[p]   = IDX_W'(cand[j]);
        wb_data[p]  = $urandom;
        cand.delete(j);
      end
    end
  endtask

  task automatic oldest_wb();
    int p;
    p = 0;
    foreach (q[i]) begin
      if (!q[i].done && p < int'(WB)) begin
        wb_valid[p] = 1'b1;
        wb_idx[p]   = IDX_W'(q[i].idx);
        wb_data[p]  = $urandom;
        p++;
      end
    end
  endtask

  task automatic ack_n(input int n);
    commit_ack = CP'((1 << n) - 1);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish, time %0t", $time);
    $fatal(1);
  end

  initial begin
    idle();
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    chk("rst_alloc_ready", 64'(alloc_ready), 64'd1);
    chk("rst_alloc_idx", 64'(alloc_idx), 64'd0);
    chk("rst_issued", 64'(issued), 64'd0);
    chk("rst_commit_valid", 64'(commit_valid), 64'd0);
    chk("rst_commit_data", 64'(commit_data), 64'd0);
    chk("rst_rs_busy", 64'(rs_busy), 64'd0);
    chk("rst_rs_fwd_valid", 64'(rs_fwd_valid), 64'd0);

    for (int i = 0; i < 8; i++) begin
      alloc_valid = 1; alloc_rd = RW'(i + 1); alloc_pc = 32'(32'h1000 + 4 * i);
      #1;
      chk("fill_idx", 64'(alloc_idx), 64'(i));
      tick();
    end
    chk("full_ready", 64'(alloc_ready), 64'd0);
    alloc_valid = 1; alloc_rd = 5'd9; alloc_pc = 32'h2000;
    tick();
    chk("ninth_idx", 64'(alloc_idx), 64'd0);
    chk("ninth_ready", 64'(alloc_ready), 64'd0);

    #2 rst_n = 1'b0;
    #1;
    chk("arst_ready", 64'(alloc_ready), 64'd1);
    chk("arst_idx", 64'(alloc_idx), 64'd0);
    chk("arst_commit_valid", 64'(commit_valid), 64'd0);
    q.delete(); m_tail = 0;
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    alloc_one(1, 32'h100); alloc_one(2, 32'h104); alloc_one(3, 32'h108);
    wb_valid = 2'b01; wb_idx[0] = 3'd2; wb_data[0] = 32'h22;
    tick();
    chk("ooo_cv_a", 64'(commit_valid), 64'd0);
    wb_valid = 2'b01; wb_idx[0] = 3'd1; wb_data[0] = 32'h11;
    tick();
    chk("ooo_cv_b", 64'(commit_valid), 64'd0);
    wb_valid = 2'b01; wb_idx[0] = 3'd0; wb_data[0] = 32'h10;
    #1;
    chk("ooo_cv_same_cycle", 64'(commit_valid), 64'd0);
    tick();
    chk("ooo_cv_all", 64'(commit_valid), 64'b111);
    chk("ooo_rd0", 64'(commit_rd[0]), 64'd1);
    chk("ooo_rd1", 64'(commit_rd[1]), 64'd2);
    chk("ooo_rd2", 64'(commit_rd[2]), 64'd3);
    chk("ooo_data2", 64'(commit_data[2]), 64'h22);
    ack_n(3);
    tick();
    chk("ooo_drained", 64'(commit_valid), 64'd0);

    flush = 1;
    tick();
    alloc_one(5, 32'h300); alloc_one(5, 32'h304);
    wb_valid = 2'b01; wb_idx[0] = 3'd0; wb_data[0] = 32'hAA; rs[0] = 5'd5;
    #1;
    chk("fwd_busy_a", 64'(rs_busy[0]), 64'd1);
    chk("fwd_valid_a", 64'(rs_fwd_valid[0]), 64'd0);
    tick();
    wb_valid = 2'b10; wb_idx[1] = 3'd1; wb_data[1] = 32'hBB; rs[0] = 5'd5;
    #1;
    chk("fwd_byp_valid", 64'(rs_fwd_valid[0]), 64'd1);
    chk("fwd_byp_data", 64'(rs_fwd_data[0]), 64'hBB);
    chk("fwd_byp_busy", 64'(rs_busy[0]), 64'd0);
    tick();
    rs[0] = 5'd5; rs[1] = 5'd0;
    #1;
    chk("fwd_done_valid", 64'(rs_fwd_valid[0]), 64'd1);
    chk("fwd_done_data", 64'(rs_fwd_data[0]), 64'hBB);
    chk("fwd_rs0_none", 64'(rs_fwd_valid[1]), 64'd0);
    tick();

    flush = 1;
    tick();
    for (int i = 0; i < 8; i++) alloc_one(i + 10, 32'h400 + 4 * i);
    for (int i = 0; i < 4; i++) begin
      wb_valid = 2'b11;
      wb_idx[0] = IDX_W'(2 * i); wb_data[0] = $urandom;
      wb_idx[1] = IDX_W'(2 * i + 1); wb_data[1] = $urandom;
      tick();
    end
    ack_n(2); alloc_valid = 1; alloc_rd = 5'd20; alloc_pc = 32'h500;
    #1;
    chk("sim_full_ready", 64'(alloc_ready), 64'd0);
    tick();
    chk("sim_ready_back", 64'(alloc_ready), 64'd1);
    chk("sim_tail_held", 64'(alloc_idx), 64'd0);
    ack_n(1); alloc_valid = 1; alloc_rd = 5'd21; alloc_pc = 32'h504;
    tick();
    chk("sim_count6_ready", 64'(alloc_ready), 64'd1);
    chk("sim_tail", 64'(alloc_idx), 64'd1);

    flush = 1; alloc_valid = 1; alloc_rd = 5'd22; alloc_pc = 32'h600;
    wb_valid = 2'b01; wb_idx[0] = 3'd0; wb_data[0] = 32'h5A; ack_n(1);
    tick();
    rs[0] = 5'd21;
    #1;
    chk("flush_cv", 64'(commit_valid), 64'd0);
    chk("flush_idx", 64'(alloc_idx), 64'd0);
    chk("flush_busy", 64'(rs_busy), 64'd0);
    chk("flush_ready", 64'(alloc_ready), 64'd1);
    tick();

    for (int c = 0; c < 24; c++) begin
      alloc_valid = 1; alloc_rd = RW'($urandom_range(1, 7)); alloc_pc = $urandom;
      oldest_wb();
      ack_n(exp_commit_n());
      rs[0] = RW'($urandom_range(0, 7)); rs[1] = RW'($urandom_range(0, 7));
      tick();
    end

    for (int c = 0; c < 500; c++) begin
      if ($urandom_range(0, 59) == 0) flush = 1;
      alloc_valid = ($urandom_range(0, 9) < 7);
      alloc_rd = RW'($urandom_range(0, 7));
      alloc_pc = $urandom;
      if (q.size() > 0 && $urandom_range(0, 1) == 1) begin
        issue_valid = 1;
        issue_idx = IDX_W'(q[$urandom_range(0, q.size() - 1)].idx);
      end
      rand_wb(int'(WB));
      ack_n(int'($urandom_range(0, exp_commit_n())));
      rs[0] = RW'($urandom_range(0, 7));
      rs[1] = RW'($urandom_range(0, 7));
      tick();
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
